axis_frame_pad: RTL



---
 rtl/axis_frame_pad.sv | 114 +++++++++++
 1 files changed

// File: rtl/axis_frame_pad.sv
// Byte-wide AXI4-Stream stage that zero-pads frames shorter than MIN_LEN.
// Pass-through is combinational; upstream is held off while pad bytes are emitted.
module axis_frame_pad #(
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned CNT_WIDTH  = $clog2(MIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  stat_pad
);

  // Counter math is one bit wider than the counter so cnt+1 never wraps.
  localparam int unsigned CW1 = CNT_WIDTH + 1;
  localparam logic [CW1-1:0] MIN_W      = CW1'(MIN_LEN);
  localparam logic [CW1-1:0] LAST_PAD_W = CW1'(MIN_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(MIN_LEN);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [USER_WIDTH-1:0] user_lat, user_lat_nxt;
  logic                  stat_pad_nxt;
  logic [CW1-1:0]        cnt_ext, cnt_inc;
  logic                  short_last;
  logic                  pad_last;

  assign cnt_ext    = {1'b0, cnt};
  assign cnt_inc    = cnt_ext + CW1'(1);
  assign short_last = s_axis_tlast && (cnt_inc < MIN_W);
  assign pad_last   = (cnt_ext == LAST_PAD_W);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_PASS;
      cnt      <= '0;
      user_lat <= '0;
      stat_pad <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      user_lat <= user_lat_nxt;
      stat_pad <= stat_pad_nxt;
    end
  end

  // Next-state and stream outputs
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    user_lat_nxt  = user_lat;
    stat_pad_nxt  = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;

    case (state)
      ST_PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast && !short_last;
        // A short frame's real last byte becomes a mid-frame beat.
        m_axis_tuser  = short_last ? '0 : s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready) begin
          if (!s_axis_tlast) begin
            cnt_nxt = (cnt_inc >= MIN_W) ? CNT_SAT : CNT_WIDTH'(cnt_inc);
          end else if (!short_last) begin
            cnt_nxt = '0;
          end else begin
            cnt_nxt      = CNT_WIDTH'(cnt_inc);
            user_lat_nxt = s_axis_tuser;
            stat_pad_nxt = 1'b1;
            state_nxt    = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = pad_last;
        m_axis_tuser  = pad_last ? user_lat : '0;
        if (m_axis_tready) begin
          if (pad_last) begin
            cnt_nxt   = '0;
            state_nxt = ST_PASS;
          end else begin
            cnt_nxt = CNT_WIDTH'(cnt_inc);
          end
        end
      end

      default: state_nxt = ST_PASS;
    endcase
  end

endmodule
